// File: rtl/fifo_ser_pkg.sv
// Shared state encoding, frame levels and sizing helper for the FIFO word serializer.
package fifo_ser_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_POP    = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    POP    = ST_POP,
    LOAD   = ST_LOAD,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_word_serializer_bit_tick_gen.sv
// Baud counter: tick marks the last cycle of each bit period, preTick the one before it.
module bit_tick_gen
  import fifo_ser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic run,
  output logic tick,
  output logic preTick
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = (CLKS_PER_BIT > 1) ? CW'(CLKS_PER_BIT - 2) : '0;

  logic [CW-1:0] cnt_q;

  assign tick    = run && (cnt_q == LAST);
  // With one clock per bit every cycle is the last one, so there is no "next-to-last".
  assign preTick = (CLKS_PER_BIT > 1) && run && (cnt_q == PRE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                cnt_q <= '0;
    else if (clear || tick)  cnt_q <= '0;
    else if (run)            cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from the FIFO and sends each as start, DATA_W bits MSB-first, even parity, stop.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              enable,
  input  logic              fifoEmpty,
  input  logic [DATA_W-1:0] fifoData,
  output logic              fifoRD,
  output logic              txLine,
  output logic              txBusy,
  output logic              wordDone
);

  localparam int BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shl;
  logic [BW-1:0]     bitCnt_q;
  logic              parity_q;
  logic              txLine_q, fifoRD_q, txBusy_q, wordDone_q;
  logic              bitTimed, tick, preTick;

  assign bitTimed = state_q inside {START, DATA, PARITY, STOP};
  assign shl      = shift_q << 1;

  // Held clear outside bit-timed states, so every START entry begins at zero.
  bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .Clk     (Clk),
    .Rst     (Rst),
    .clear   (!bitTimed),
    .run     (bitTimed),
    .tick    (tick),
    .preTick (preTick)
  );

  // Outputs are loaded with the value they must carry in the state being entered.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitCnt_q   <= '0;
      parity_q   <= 1'b0;
      txLine_q   <= IDLE_LEVEL;
      fifoRD_q   <= 1'b0;
      txBusy_q   <= 1'b0;
      wordDone_q <= 1'b0;
    end else begin
      fifoRD_q   <= 1'b0;
      wordDone_q <= 1'b0;
      case (state_q)
        IDLE: if (enable && !fifoEmpty) begin
          state_q  <= POP;
          fifoRD_q <= 1'b1;
          txBusy_q <= 1'b1;
        end
        POP: state_q <= LOAD;
        LOAD: begin
          shift_q  <= fifoData;
          parity_q <= ^fifoData;
          txLine_q <= START_BIT;
          state_q  <= START;
        end
        START: if (tick) begin
          bitCnt_q <= '0;
          txLine_q <= shift_q[DATA_W-1];
          state_q  <= DATA;
        end
        DATA: if (tick) begin
          if (bitCnt_q == LAST_BIT) begin
            txLine_q <= parity_q;
            state_q  <= PARITY;
          end else begin
            bitCnt_q <= bitCnt_q + BW'(1);
            shift_q  <= shl;
            txLine_q <= shl[DATA_W-1];
          end
        end
        PARITY: if (tick) begin
          txLine_q   <= STOP_BIT;
          wordDone_q <= (CLKS_PER_BIT == 1);
          state_q    <= STOP;
        end
        STOP: begin
          if (tick) begin
            txLine_q <= IDLE_LEVEL;
            txBusy_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            wordDone_q <= preTick;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifoRD   = fifoRD_q;
  assign txLine   = txLine_q;
  assign txBusy   = txBusy_q;
  assign wordDone = wordDone_q;

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
Downstream consumer of the 32-bit, 8-deep word FIFO (fifo_n).
- Pops one word at a time when the FIFO is non-empty and the block is enabled.
- Transmits each word on a single-wire serial line as a UART-like frame: start bit, 32 data bits MSB-first, even parity, stop bit.
- Sits between the FIFO read port and the off-chip or board-level serial link.

Parameters:
- DATA_W, 32: word width; must match the FIFO data width.
- CLKS_PER_BIT, 4: Clk cycles per serial bit; legal range 1 to 65535.

Ports:
- Clk  in  1: system clock, rising edge.
- Rst  in  1: reset, asynchronous, active-low.
- enable  in  1: allow new frames to start; sampled only in IDLE.
- fifoEmpty  in  1: FIFO EMPTY flag.
- fifoData  in  DATA_W: FIFO dataOut; registered in the FIFO, valid on the edge after RD is sampled.
- fifoRD  out  1: FIFO RD strobe; one-cycle pulse per word.
- txLine  out  1: serial output; idles high.
- txBusy  out  1: high from POP through STOP inclusive.
- wordDone  out  1: one-cycle pulse in the last cycle of STOP.

Behaviour:
Clock and reset
- Single clock domain on Clk.
- Rst low asynchronously forces: state=IDLE, txLine=1, fifoRD=0, txBusy=0, wordDone=0, shift register=0, counters=0.
- All outputs are driven from registers or decoded from the state register only; no input-to-output combinational paths.

FSM states
- IDLE: txLine=1. If enable=1 and fifoEmpty=0, go to POP; otherwise stay.
- POP: fifoRD=1 for exactly this one cycle. Always go to LOAD.
- LOAD: capture fifoData into the shift register and compute parity = XOR-reduce of the captured word. Go to START.
- START: txLine=0 for CLKS_PER_BIT cycles. Go to DATA.
- DATA: txLine = shift[DATA_W-1]; each bit is held CLKS_PER_BIT cycles, then shift left by 1.
  - bitCnt counts 0 to DATA_W-1.
  - After bit DATA_W-1, go to PARITY.
- PARITY: txLine = parity for CLKS_PER_BIT cycles. The total count of ones across data bits plus parity is even.
- STOP: txLine=1 for CLKS_PER_BIT cycles. wordDone=1 in its final cycle. Go to IDLE unconditionally.

Timing
- Frame length from the first START cycle to the last STOP cycle is (DATA_W+3)*CLKS_PER_BIT cycles; 140 at the defaults.
- Minimum gap between frames (line high after a stop bit, before the next start bit) is 3 cycles: IDLE, POP, LOAD.
- Baud counter width is clog2(CLKS_PER_BIT), minimum 1. It resets to 0 on every state entry. A bit ends when the counter equals CLKS_PER_BIT-1.

Boundary conditions
- fifoEmpty=1 in IDLE: fifoRD is never asserted. There is no read-underflow path.
- fifoEmpty changing during POP through STOP: ignored, because the pop decision is made only in IDLE.
- enable deasserted mid-frame: the current frame completes, then the block stays in IDLE.
- Reset mid-frame: txLine goes high immediately and the in-flight word is discarded. That word is not re-read, because the FIFO has already advanced.
- CLKS_PER_BIT=1: every bit lasts exactly 1 cycle. There are no zero-length states.

Decomposition:
Package fifo_ser_pkg holds:
- state encoding: IDLE, POP, LOAD, START, DATA, PARITY, STOP, as 3-bit localparams;
- frame constants: START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.

One sub-module, bit_tick_gen:
- Parameterised by CLKS_PER_BIT.
- Inputs: clear, run.
- Output: tick, asserted in the last cycle of each bit period.
- Used by the FSM for every bit-timed state.

Test Plan:
1. Reset: hold Rst=0 with random inputs; release mid-cycle.
   -> txLine=1, fifoRD=0, txBusy=0, wordDone=0 immediately, with no Clk edge required.
2. Single word at defaults: fifoData=32'hA5A5_0001, fifoEmpty=0 for one pop, enable=1.
   -> One fifoRD pulse.
   -> START low for 4 cycles.
   -> Data bits MSB-first: 1,0,1,0,0,1,0,1, ... 0,0,0,1.
   -> Parity=1 (nine ones in the word).
   -> Stop high.
   -> wordDone exactly 140 cycles after the first START cycle, inclusive.
3. Empty FIFO: fifoEmpty=1, enable=1 for 200 cycles.
   -> fifoRD stays 0, txLine stays 1, txBusy stays 0.
4. Back-to-back: FIFO model preloaded with 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001.
   -> Three fifoRD pulses and three wordDone pulses.
   -> Parity bits 0, 0, 1.
   -> Exactly 3 high cycles between each stop bit and the next start bit.
5. Reset mid-frame: assert Rst=0 while sending DATA bit 10 of 32'h1234_5678; release with the next word 32'h0000_00FF pending.
   -> txLine=1 at once.
   -> After release, a fresh POP and a complete frame carrying 32'h0000_00FF with parity 0.
6. Enable drop: deassert enable during PARITY with 2 words queued.
   -> Current frame finishes with wordDone.
   -> No further fifoRD until enable returns high.
